// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends one shared up-counter to the
// granted requester until it reaches that requester's target value.
module counter_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_tgt;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_count;

    state_t           w_state_next;
    logic             w_ptr_next;
    logic [WIDTH-1:0] w_tgt_next;
    logic [1:0]       w_gnt_next;
    logic [1:0]       w_done_next;
    logic [WIDTH-1:0] w_count_next;

    logic             w_owner;
    logic             w_owner_req;
    logic             w_grant_idx;
    logic [1:0]       w_grant_onehot;
    logic [WIDTH-1:0] w_grant_tgt;

    // gnt is one-hot while owned, so its upper bit names the owner
    assign w_owner     = r_gnt[1];
    assign w_owner_req = req[w_owner];
    assign w_grant_idx = (req == 2'b11) ? r_ptr : req[1];
    assign w_grant_tgt = w_grant_idx ? target1 : target0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign w_grant_onehot[gi] = (w_grant_idx == 1'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_tgt_next   = r_tgt;
        w_gnt_next   = r_gnt;
        w_done_next  = 2'b00;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_next = S_COUNT;
                    w_gnt_next   = w_grant_onehot;
                    w_tgt_next   = w_grant_tgt;
                    w_count_next = '0;
                end
            end
            S_COUNT: begin
                if (abort || !w_owner_req) begin
                    w_state_next = S_IDLE;
                    w_gnt_next   = 2'b00;
                    w_ptr_next   = ~w_owner;
                end else if (r_count == r_tgt) begin
                    w_state_next = S_DONE;
                    w_done_next  = r_gnt;
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end
            S_DONE: begin
                // abort and normal completion release the counter identically here
                w_state_next = S_IDLE;
                w_gnt_next   = 2'b00;
                w_ptr_next   = ~w_owner;
            end
            default: begin
                w_state_next = S_IDLE;
                w_gnt_next   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_tgt   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_tgt   <= w_tgt_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_count <= w_count_next;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = (r_state != S_IDLE);
    assign count = r_count;

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the targets and of the shared counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset; reset = 0 sampled at a rising clk edge resets the block.
REQ-004 SHALL have port req, input, 2: req[i] high = requester i wants an interval; held high until done[i], or dropped to abort.
REQ-005 SHALL have port target0, input, WIDTH: interval length for requester 0; sampled only at grant.
REQ-006 SHALL have port target1, input, WIDTH: interval length for requester 1; sampled only at grant.
REQ-007 SHALL have port abort, input, 1: global cancel of the current interval.
REQ-008 SHALL have port gnt, output, 2: registered, one-hot or zero; owner of the shared counter.
REQ-009 SHALL have port done, output, 2: registered; one-cycle completion pulse to the owner.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port count, output, WIDTH: current shared counter value.

Function
REQ-012 SHALL implement FSM states IDLE, COUNT and DONE, plus a 1-bit round-robin pointer ptr.
REQ-013 SHALL in IDLE grant requester ptr when both req bits are high, the sole requester when one is high, and stay in IDLE when none is high.
REQ-014 SHALL, on the grant edge, set gnt one-hot, latch the requester's target into tgt, clear count to 0 and enter COUNT; gnt is visible the cycle after req is first sampled high.
REQ-015 SHALL in COUNT increment count by 1 each cycle while count != tgt.
REQ-016 SHALL in COUNT, at the edge where count == tgt, enter DONE with count held at tgt.
REQ-017 SHALL, for target 0, take the COUNT-to-DONE transition on the first COUNT edge.
REQ-018 SHALL in DONE assert done[owner] for exactly one cycle with gnt still asserted.
REQ-019 SHALL, on the next edge after DONE, clear gnt, set ptr to the non-owner index and return to IDLE.
REQ-020 SHALL give a total gnt-high time of tgt+2 cycles for a completed interval.
REQ-021 SHALL leave at least one IDLE cycle (gnt = 0) between consecutive grants.
REQ-022 SHALL treat abort high in COUNT or DONE as an abort: next edge clears gnt and done, enters IDLE, sets ptr to the non-owner and holds count; no done pulse follows.
REQ-023 SHALL treat the owner dropping req in COUNT exactly as an abort.
REQ-024 SHALL ignore abort in IDLE.
REQ-025 SHALL, in DONE, give abort priority over normal completion; the done pulse already on the outputs is not retracted.
REQ-026 SHALL ignore target changes after the grant edge.
REQ-027 SHALL ignore the non-owner's req while the owner holds the grant.
REQ-028 SHALL never wrap count: maximum tgt = 2^WIDTH-1 is reached without overflow, and all arithmetic is WIDTH bits.
REQ-029 SHALL, in IDLE, hold count at its last value.

Reset
REQ-030 SHALL, when reset = 0 at a rising edge in any state, force state = IDLE, ptr = 0, tgt = 0, gnt = 2'b00, done = 2'b00, busy = 0 and count = 0 from the next cycle.
REQ-031 SHALL give reset priority over req and abort.
REQ-032 SHALL emit no done pulse when reset occurs mid-interval.
REQ-033 SHALL leave all outputs in their reset values until a req is sampled after reset is released.

Verification
REQ-034 SHALL be tested with: reset 0 then 1, req = 01, target0 = 3 -> gnt = 01 next cycle; count = 0,1,2,3,3; done = 01 on the 5th gnt cycle; gnt low after it.
REQ-035 SHALL be tested with: req = 11 held from reset, targets 2/5 -> grants in order 01, 10, 01, ...; each done matches the owner; one IDLE cycle between grants.
REQ-036 SHALL be tested with: target0 = 0 -> gnt high 2 cycles; done on the 2nd; count stays 0.
REQ-037 SHALL be tested with: target1 = 255 with req = 10 -> count climbs to 255 without wrap; done[1] after 257 gnt cycles.
REQ-038 SHALL be tested with: abort, or owner req dropped, at count = 4 of target 9 -> gnt = 00 next cycle; no done; count holds 4; other requester granted after the IDLE cycle.
REQ-039 SHALL be tested with: reset = 0 at count = 6 -> next cycle all outputs 0; ptr = 0, so with req = 11 requester 0 is granted first.
